// File: rtl/ft_alu_pkg.sv
// Shared types and helpers for the fault-tolerant ALU issuer.
// Op/status codes, bus codeword, parity, control and check functions.
package ft_alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUBAB = 2'b01,
      OP_SUBBA = 2'b10,
      OP_ILL   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_OK         = 2'b00,
      ST_OK_RETRIED = 2'b01,
      ST_FAIL       = 2'b10,
      ST_ILLEGAL    = 2'b11
   } status_e;

   // c is {C2,C1,C0}
   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
      logic       par;
      logic [2:0] c;
   } bus_t;

   typedef struct packed {
      logic [2:0] x;
      logic       xc;
      logic       xe0;
      logic       xe1;
      logic [2:0] y;
      logic       yc;
      logic       ye0;
      logic       ye1;
   } sample_t;

   localparam bus_t IDLE_BUS = '{
      a:   3'd0,
      b:   3'd0,
      par: 1'b1,
      c:   3'b001
   };

   function automatic logic par_bit(
      input logic [2:0] a,
      input logic [2:0] b
   );
      return ~(^{a, b});
   endfunction

   function automatic logic [2:0] op_ctrl(input op_e op);
      logic [2:0] c;
      case (op)
         OP_SUBAB: c = 3'b010;
         OP_SUBBA: c = 3'b100;
         default:  c = 3'b001;
      endcase
      return c;
   endfunction

   function automatic logic two_rail_pass(input sample_t s);
      return !s.xe0 && s.xe1 &&
             !s.ye0 && s.ye1 &&
             (s.x == s.y) &&
             (s.xc == s.yc);
   endfunction

endpackage

// File: rtl/ft_alu_issuer_if.sv
// Request, ALU bus and response signals of the issuer.
// master = issuer side, slave = environment side.
interface ft_alu_issuer_if;

   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [2:0] req_a;
   logic [2:0] req_b;

   logic A0, A1, A2;
   logic B0, B1, B2;
   logic PAR;
   logic C0, C1, C2;

   logic X0, X1, X2, XC, XE0, XE1;
   logic Y0, Y1, Y2, YC, YE0, YE1;

   logic       rsp_valid;
   logic       rsp_ready;
   logic [2:0] rsp_sum;
   logic       rsp_carry;
   logic [1:0] rsp_status;
   logic [1:0] rsp_retries;
   logic [7:0] err_count;

   modport master (
      input  req_valid, req_op, req_a, req_b,
      output req_ready,
      output A0, A1, A2, B0, B1, B2, PAR,
      output C0, C1, C2,
      input  X0, X1, X2, XC, XE0, XE1,
      input  Y0, Y1, Y2, YC, YE0, YE1,
      output rsp_valid,
      input  rsp_ready,
      output rsp_sum, rsp_carry,
      output rsp_status, rsp_retries,
      output err_count
   );

   modport slave (
      output req_valid, req_op, req_a, req_b,
      input  req_ready,
      input  A0, A1, A2, B0, B1, B2, PAR,
      input  C0, C1, C2,
      output X0, X1, X2, XC, XE0, XE1,
      output Y0, Y1, Y2, YC, YE0, YE1,
      input  rsp_valid,
      output rsp_ready,
      input  rsp_sum, rsp_carry,
      input  rsp_status, rsp_retries,
      input  err_count
   );

endinterface

// File: rtl/ft_alu_result_check.sv
// Combinational pass/fail over a captured ALU sample.
// Both rails must be valid and the duplicated results must agree.
module ft_alu_result_check
   import ft_alu_pkg::*;
(
   input  sample_t smp_i,
   output logic    pass_o
);

   assign pass_o = two_rail_pass(smp_i);

endmodule

// File: rtl/ft_alu_issuer.sv
// Issuer FSM: encodes requests onto the ALU bus, waits the settle
// window, checks duplicated results, retries, and returns a response.
module ft_alu_issuer
   import ft_alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_RETRY     = 3
) (
   input logic             clk,
   input logic             rst,
   ft_alu_issuer_if.master io
);

   localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);
   localparam logic [1:0] RETRY_N  = 2'(MAX_RETRY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_CHECK,
      S_RESP
   } state_e;

   state_e     state_q;
   bus_t       bus_q;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] retry_q;
   sample_t    smp_q, smp_live;
   logic       pass;
   logic       req_ready_q;
   logic       rsp_valid_q;
   logic [2:0] rsp_sum_q;
   logic       rsp_carry_q;
   status_e    rsp_status_q;
   logic [1:0] rsp_retries_q;
   logic [7:0] err_q, err_d;
   op_e        op;

   assign op = op_e'(io.req_op);

   assign smp_live = '{
      x:   {io.X2, io.X1, io.X0},
      xc:  io.XC,
      xe0: io.XE0,
      xe1: io.XE1,
      y:   {io.Y2, io.Y1, io.Y0},
      yc:  io.YC,
      ye0: io.YE0,
      ye1: io.YE1
   };

   // Next settle count and saturating error count.
   always_comb begin
      cnt_d = cnt_q + 4'd1;
      err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
   end

   ft_alu_result_check u_check (
      .smp_i  (smp_q),
      .pass_o (pass)
   );

   // Issuer state machine with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         bus_q         <= IDLE_BUS;
         cnt_q         <= '0;
         retry_q       <= '0;
         smp_q         <= '0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_sum_q     <= '0;
         rsp_carry_q   <= 1'b0;
         rsp_status_q  <= ST_OK;
         rsp_retries_q <= '0;
         err_q         <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req_ready_q && io.req_valid) begin
                  req_ready_q <= 1'b0;
                  if (op == OP_ILL) begin
                     rsp_valid_q   <= 1'b1;
                     rsp_sum_q     <= '0;
                     rsp_carry_q   <= 1'b0;
                     rsp_status_q  <= ST_ILLEGAL;
                     rsp_retries_q <= '0;
                     state_q       <= S_RESP;
                  end else begin
                     bus_q <= '{
                        a:   io.req_a,
                        b:   io.req_b,
                        par: par_bit(io.req_a, io.req_b),
                        c:   op_ctrl(op)
                     };
                     cnt_q   <= '0;
                     retry_q <= '0;
                     state_q <= S_DRIVE;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            S_DRIVE: begin
               cnt_q <= cnt_d;
               if (cnt_d == SETTLE_N) begin
                  smp_q   <= smp_live;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (pass) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_sum_q     <= smp_q.x;
                  rsp_carry_q   <= smp_q.xc;
                  rsp_status_q  <= (retry_q == 2'd0) ? ST_OK
                                                     : ST_OK_RETRIED;
                  rsp_retries_q <= retry_q;
                  state_q       <= S_RESP;
               end else begin
                  err_q <= err_d;
                  if (retry_q < RETRY_N) begin
                     retry_q <= retry_q + 2'd1;
                     cnt_q   <= '0;
                     state_q <= S_DRIVE;
                  end else begin
                     rsp_valid_q   <= 1'b1;
                     rsp_sum_q     <= smp_q.x;
                     rsp_carry_q   <= smp_q.xc;
                     rsp_status_q  <= ST_FAIL;
                     rsp_retries_q <= retry_q;
                     state_q       <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (io.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  bus_q       <= IDLE_BUS;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign io.req_ready   = req_ready_q;
   assign io.A0          = bus_q.a[0];
   assign io.A1          = bus_q.a[1];
   assign io.A2          = bus_q.a[2];
   assign io.B0          = bus_q.b[0];
   assign io.B1          = bus_q.b[1];
   assign io.B2          = bus_q.b[2];
   assign io.PAR         = bus_q.par;
   assign io.C0          = bus_q.c[0];
   assign io.C1          = bus_q.c[1];
   assign io.C2          = bus_q.c[2];
   assign io.rsp_valid   = rsp_valid_q;
   assign io.rsp_sum     = rsp_sum_q;
   assign io.rsp_carry   = rsp_carry_q;
   assign io.rsp_status  = rsp_status_q;
   assign io.rsp_retries = rsp_retries_q;
   assign io.err_count   = err_q;

endmodule

// File: tb/tb_ft_alu_issuer.sv
// Bench for ft_alu_issuer: behavioural ALU with fault injection,
// reference results from plain arithmetic, directed + random runs.
module tb_ft_alu_issuer;

   localparam int SC = 2;
   localparam logic [9:0] IDLE_V = 10'b000_000_1_001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ft_alu_issuer_if bus ();

   ft_alu_issuer #(
      .SETTLE_CYCLES (SC),
      .MAX_RETRY     (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   int tests = 0;
   int fails = 0;
   int exp_err = 0;

   logic fault_on = 1'b0;
   int   fault_kind = 0;

   logic [2:0] ma, mb, mx, my;
   logic [3:0] mr;
   logic       mxc, myc, mxe0, mxe1, mye0, mye1;

   // Behavioural duplicated ALU with optional fault.
   always_comb begin
      ma = {bus.A2, bus.A1, bus.A0};
      mb = {bus.B2, bus.B1, bus.B0};
      if (bus.C1)
         mr = {1'b0, ma} + {1'b0, ~mb} + 4'd1;
      else if (bus.C2)
         mr = {1'b0, mb} + {1'b0, ~ma} + 4'd1;
      else
         mr = {1'b0, ma} + {1'b0, mb};
      mx = mr[2:0];
      mxc = mr[3];
      my = mx;
      myc = mxc;
      mxe0 = 1'b0;
      mxe1 = 1'b1;
      mye0 = 1'b0;
      mye1 = 1'b1;
      if (fault_on) begin
         case (fault_kind)
            0: mxe0 = 1'b1;
            1: my = mx ^ 3'b100;
            2: myc = ~mxc;
            default: mye1 = 1'b0;
         endcase
      end
   end

   assign bus.X0 = mx[0];
   assign bus.X1 = mx[1];
   assign bus.X2 = mx[2];
   assign bus.XC = mxc;
   assign bus.XE0 = mxe0;
   assign bus.XE1 = mxe1;
   assign bus.Y0 = my[0];
   assign bus.Y1 = my[1];
   assign bus.Y2 = my[2];
   assign bus.YC = myc;
   assign bus.YE0 = mye0;
   assign bus.YE1 = mye1;

   function automatic logic [9:0] bus_now();
      return {bus.A2, bus.A1, bus.A0, bus.B2, bus.B1, bus.B0,
              bus.PAR, bus.C2, bus.C1, bus.C0};
   endfunction

   function automatic logic [9:0] exp_bus(input int op,
                                          input int a,
                                          input int b);
      logic [2:0] aa, bb, cc;
      logic       p;
      aa = 3'(a);
      bb = 3'(b);
      p = (($countones(aa) + $countones(bb)) % 2) == 0;
      cc = 3'(1 << op);
      return {aa, bb, p, cc};
   endfunction

   task automatic ref_alu(input int op, input int a, input int b,
                          output int s, output int cy);
      case (op)
         0: begin s = (a + b) % 8; cy = (a + b >= 8) ? 1 : 0; end
         1: begin s = (a - b + 8) % 8; cy = (a >= b) ? 1 : 0; end
         2: begin s = (b - a + 8) % 8; cy = (b >= a) ? 1 : 0; end
         default: begin s = 0; cy = 0; end
      endcase
   endtask

   function automatic int sat_add(input int e, input int n);
      return (e + n > 255) ? 255 : e + n;
   endfunction

   task automatic do_req(
      input  int         op,
      input  int         a,
      input  int         b,
      input  int         nbad,
      input  int         kind,
      input  int         stall,
      output int         lat,
      output logic [9:0] busv,
      output logic [2:0] sum,
      output logic       carry,
      output logic [1:0] st,
      output logic [1:0] rtr,
      output logic       stable,
      output logic       rdy_resp,
      output logic       idle_after
   );
      int c, seen, guard;
      guard = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      bus.req_valid = 1'b1;
      bus.req_op = 2'(op);
      bus.req_a = 3'(a);
      bus.req_b = 3'(b);
      fault_kind = kind;
      fault_on = (nbad > 0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      busv = bus_now();
      c = 0;
      seen = 0;
      while (bus.rsp_valid !== 1'b1 && c < 60) begin
         @(posedge clk);
         c++;
         #1;
         if (fault_on && (c % (SC + 1)) == SC) begin
            seen++;
            if (seen >= nbad) fault_on = 1'b0;
         end
      end
      fault_on = 1'b0;
      lat = (bus.rsp_valid === 1'b1 && guard < 20) ? c : -1;
      sum = bus.rsp_sum;
      carry = bus.rsp_carry;
      st = bus.rsp_status;
      rtr = bus.rsp_retries;
      rdy_resp = bus.req_ready;
      stable = 1'b1;
      repeat (stall) begin
         @(posedge clk);
         #1;
         if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_carry,
              bus.rsp_status, bus.rsp_retries} !==
             {1'b1, sum, carry, st, rtr})
            stable = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      idle_after = (bus.rsp_valid === 1'b0) && (bus_now() === IDLE_V);
   endtask

   task automatic test_reset();
      #12;
      tests++;
      if (bus.req_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready got=%b want=0", bus.req_ready);
      end
      tests++;
      if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_status,
           bus.rsp_retries, bus.err_count} !== 16'd0) begin
         fails++;
         $display("FAIL reset_rsp got=%b%b%b%b%b%h want=0",
                  bus.rsp_valid, bus.rsp_sum, bus.rsp_carry,
                  bus.rsp_status, bus.rsp_retries, bus.err_count);
      end
      tests++;
      if (bus_now() !== IDLE_V) begin
         fails++;
         $display("FAIL reset_bus got=%b want=%b", bus_now(), IDLE_V);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready_first_edge got=%b want=1",
                  bus.req_ready);
      end
   endtask

   task automatic test_directed();
      int ops[3] = '{0, 1, 2};
      int as[3] = '{3, 5, 1};
      int bs[3] = '{2, 3, 4};
      int es, ec, lat;
      logic [9:0] bv;
      logic [2:0] s;
      logic cy, stb, rr, ia;
      logic [1:0] st, rt;
      for (int i = 0; i < 3; i++) begin
         ref_alu(ops[i], as[i], bs[i], es, ec);
         do_req(ops[i], as[i], bs[i], 0, 0, 0,
                lat, bv, s, cy, st, rt, stb, rr, ia);
         tests++;
         if (bv !== exp_bus(ops[i], as[i], bs[i])) begin
            fails++;
            $display("FAIL dir%0d_bus got=%b want=%b",
                     i, bv, exp_bus(ops[i], as[i], bs[i]));
         end
         tests++;
         if (s !== 3'(es) || cy !== 1'(ec) || st !== 2'b00 ||
             rt !== 2'd0 || lat != SC + 1) begin
            fails++;
            $display("FAIL dir%0d_rsp got=%0d/%0d/%0d/%0d lat%0d want=%0d/%0d/0/0 lat%0d",
                     i, s, cy, st, rt, lat, es, ec, SC + 1);
         end
      end
   endtask

   task automatic test_retry();
      int lat;
      logic [9:0] bv;
      logic [2:0] s;
      logic cy, stb, rr, ia;
      logic [1:0] st, rt;
      do_req(0, 1, 1, 1, 0, 0, lat, bv, s, cy, st, rt, stb, rr, ia);
      exp_err = sat_add(exp_err, 1);
      tests++;
      if (s !== 3'd2 || cy !== 1'b0 || st !== 2'b01 || rt !== 2'd1 ||
          lat != 2 * (SC + 1)) begin
         fails++;
         $display("FAIL retry_rsp got=%0d/%0d/%0d/%0d lat%0d want=2/0/1/1 lat%0d",
                  s, cy, st, rt, lat, 2 * (SC + 1));
      end
      tests++;
      if (bus.err_count !== 8'(exp_err)) begin
         fails++;
         $display("FAIL retry_err got=%0d want=%0d", bus.err_count, exp_err);
      end
   endtask

   task automatic test_fail();
      int lat, es, ec;
      logic [9:0] bv;
      logic [2:0] s;
      logic cy, stb, rr, ia;
      logic [1:0] st, rt;
      ref_alu(1, 6, 2, es, ec);
      do_req(1, 6, 2, 99, 1, 0, lat, bv, s, cy, st, rt, stb, rr, ia);
      exp_err = sat_add(exp_err, 4);
      tests++;
      if (s !== 3'(es) || cy !== 1'(ec) || st !== 2'b10 ||
          rt !== 2'd3 || lat != 4 * (SC + 1)) begin
         fails++;
         $display("FAIL fail_rsp got=%0d/%0d/%0d/%0d lat%0d want=%0d/%0d/2/3 lat%0d",
                  s, cy, st, rt, lat, es, ec, 4 * (SC + 1));
      end
      tests++;
      if (bus.err_count !== 8'(exp_err)) begin
         fails++;
         $display("FAIL fail_err got=%0d want=%0d", bus.err_count, exp_err);
      end
   endtask

   task automatic test_illegal();
      int lat;
      logic [9:0] bv;
      logic [2:0] s;
      logic cy, stb, rr, ia;
      logic [1:0] st, rt;
      do_req(3, 7, 5, 0, 0, 1, lat, bv, s, cy, st, rt, stb, rr, ia);
      tests++;
      if (s !== 3'd0 || cy !== 1'b0 || st !== 2'b11 || rt !== 2'd0 ||
          lat != 0 || bv !== IDLE_V) begin
         fails++;
         $display("FAIL illegal got=%0d/%0d/%0d/%0d lat%0d bus=%b want=0/0/3/0 lat0 bus=%b",
                  s, cy, st, rt, lat, bv, IDLE_V);
      end
   endtask

   task automatic test_random();
      int op, a, b, nbad, kind, es, ec, lat, elat, est, ert;
      logic [9:0] bv, ebv;
      logic [2:0] s;
      logic cy, stb, rr, ia;
      logic [1:0] st, rt;
      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 3));
         a = int'($urandom_range(0, 7));
         b = int'($urandom_range(0, 7));
         nbad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
         kind = int'($urandom_range(0, 3));
         if (op == 3) nbad = 0;
         ref_alu(op, a, b, es, ec);
         if (op == 3) begin
            elat = 0; est = 3; ert = 0; ebv = IDLE_V;
         end else if (nbad <= 3) begin
            elat = (nbad + 1) * (SC + 1);
            est = (nbad > 0) ? 1 : 0;
            ert = nbad;
            ebv = exp_bus(op, a, b);
            exp_err = sat_add(exp_err, nbad);
         end else begin
            elat = 4 * (SC + 1); est = 2; ert = 3;
            ebv = exp_bus(op, a, b);
            exp_err = sat_add(exp_err, 4);
         end
         do_req(op, a, b, nbad, kind, int'($urandom_range(0, 3)),
                lat, bv, s, cy, st, rt, stb, rr, ia);
         tests++;
         if (s !== 3'(es) || cy !== 1'(ec) || st !== 2'(est) ||
             rt !== 2'(ert) || lat != elat || bv !== ebv) begin
            fails++;
            $display("FAIL rand%0d op%0d a%0d b%0d bad%0d got=%0d/%0d/%0d/%0d lat%0d bus=%b want=%0d/%0d/%0d/%0d lat%0d bus=%b",
                     i, op, a, b, nbad, s, cy, st, rt, lat, bv,
                     es, ec, est, ert, elat, ebv);
         end
         tests++;
         if (stb !== 1'b1 || rr !== 1'b0 || ia !== 1'b1) begin
            fails++;
            $display("FAIL rand%0d_hs stable=%b ready_in_resp=%b idle_after=%b want=1/0/1",
                     i, stb, rr, ia);
         end
         tests++;
         if (bus.err_count !== 8'(exp_err)) begin
            fails++;
            $display("FAIL rand%0d_err got=%0d want=%0d",
                     i, bus.err_count, exp_err);
         end
      end
   endtask

   task automatic test_saturation();
      int lat;
      logic [9:0] bv;
      logic [2:0] s;
      logic cy, stb, rr, ia;
      logic [1:0] st, rt;
      for (int i = 0; i < 66; i++) begin
         do_req(0, i % 8, 3, 99, i % 4, 0,
                lat, bv, s, cy, st, rt, stb, rr, ia);
         exp_err = sat_add(exp_err, 4);
      end
      tests++;
      if (bus.err_count !== 8'd255 || exp_err != 255) begin
         fails++;
         $display("FAIL sat_err got=%0d want=255", bus.err_count);
      end
      do_req(0, 2, 2, 1, 3, 0, lat, bv, s, cy, st, rt, stb, rr, ia);
      tests++;
      if (bus.err_count !== 8'd255 || st !== 2'b01) begin
         fails++;
         $display("FAIL sat_hold got=%0d st%0d want=255 st1",
                  bus.err_count, st);
      end
   endtask

   task automatic test_async_reset();
      int guard, lat;
      logic [9:0] bv;
      logic [2:0] s;
      logic cy, stb, rr, ia;
      logic [1:0] st, rt;
      guard = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      bus.req_valid = 1'b1;
      bus.req_op = 2'd1;
      bus.req_a = 3'd6;
      bus.req_b = 3'd5;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (bus_now() !== IDLE_V || bus.rsp_valid !== 1'b0 ||
          bus.req_ready !== 1'b0 || bus.err_count !== 8'd0) begin
         fails++;
         $display("FAIL async_rst bus=%b valid=%b ready=%b err=%0d want bus=%b 0/0/0",
                  bus_now(), bus.rsp_valid, bus.req_ready,
                  bus.err_count, IDLE_V);
      end
      exp_err = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL async_ready got=%b want=1", bus.req_ready);
      end
      do_req(2, 2, 7, 0, 0, 0, lat, bv, s, cy, st, rt, stb, rr, ia);
      tests++;
      if (s !== 3'd5 || cy !== 1'b1 || st !== 2'b00 ||
          bus.err_count !== 8'd0) begin
         fails++;
         $display("FAIL async_recover got=%0d/%0d/%0d err%0d want=5/1/0 err0",
                  s, cy, st, bus.err_count);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op = 2'd0;
      bus.req_a = 3'd0;
      bus.req_b = 3'd0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_directed();
      test_retry();
      test_fail();
      test_illegal();
      test_random();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
